masked_inv_scheduler: RTL and testbench

Round-robin scheduler that shares one masked 4-stage GF(2^8) inverter pipeline among `NUM_REQ` requesters, such as state-byte S-box lanes and key-schedule S-box lanes. It accepts at most one masked byte per cycle and drives it into the inverter. It tracks each in-flight operation's requester through a valid/ID shift pipeline matched to the inverter latency, then routes the inverter output back to the originating requester. The inverter is free-running and cannot stall, so the scheduler never applies backpressure to responses.

---
 rtl/masked_inv_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_masked_inv_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/masked_inv_scheduler.sv
// masked_inv_scheduler
//
// Shares one free-running, masked GF(2^8) inverter pipeline among NUM_REQ
// requesters. A combinational round-robin arbiter grants at most one masked
// byte per cycle and drives it onto the inverter input. A valid/ID shift
// pipeline whose depth matches the inverter latency tracks each operation.
// When the operation leaves the inverter, the pipeline routes the result back
// to the requester that issued it. The inverter cannot stall, so responses are
// never backpressured.
//
// Shares are carried as packed [NUM_SHARES-1:0][7:0] vectors, one 8-bit
// element per Boolean share. No logic in this block ever combines shares.
//
// Parameters:
//   NUM_SHARES  Boolean shares per byte
//   NUM_REQ     number of requesters (2..16)
//   LATENCY     inverter register depth, input to output
//
// Ports:
//   in_clock         clock
//   in_reset         synchronous, active-high reset
//   in_enable        low = no new grants; in-flight operations still complete
//   in_req_valid     request pending, one bit per requester
//   in_req_data      masked operand per requester
//   out_req_ready    one-hot grant (transfer = valid & ready)
//   out_inv_a        shares driven to the inverter input
//   in_inv_b         shares returned by the inverter
//   out_resp_valid   one-hot, result for that requester is present this cycle
//   out_resp_data    masked inverse (pass-through of in_inv_b)
//   out_busy         at least one operation is in flight
//   out_issue_count  saturating count of accepted operations
//
// Build option:
//   MASKED_INV_SCHED_IDLE_ZERO_EN
//     defined   : on idle cycles out_inv_a is driven to all-zero shares
//     undefined : on idle cycles out_inv_a holds the last granted operand

module masked_inv_scheduler #(
    parameter int NUM_SHARES = 2,
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = 4
) (
    input  logic                                  in_clock,
    input  logic                                  in_reset,
    input  logic                                  in_enable,
    input  logic [NUM_REQ-1:0]                    in_req_valid,
    input  logic [NUM_REQ-1:0][NUM_SHARES-1:0][7:0] in_req_data,
    output logic [NUM_REQ-1:0]                    out_req_ready,
    output logic [NUM_SHARES-1:0][7:0]            out_inv_a,
    input  logic [NUM_SHARES-1:0][7:0]            in_inv_b,
    output logic [NUM_REQ-1:0]                    out_resp_valid,
    output logic [NUM_SHARES-1:0][7:0]            out_resp_data,
    output logic                                  out_busy,
    output logic [15:0]                           out_issue_count
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_next;
    logic [PW-1:0]      grant_idx;
    logic               grant_any;
    logic [NUM_REQ-1:0] grant;

    // Candidate requester index for each priority slot, (ptr + k) mod NUM_REQ.
    // One extra bit holds the sum before the wrap.
    logic [PW:0] cand_sum [NUM_REQ];
    logic [PW:0] cand     [NUM_REQ];

    logic               stage_valid [LATENCY];
    logic [NUM_REQ-1:0] stage_id    [LATENCY];

    logic [NUM_SHARES-1:0][7:0] idle_a;

    // ------------------------------------------------------------------
    // Round-robin arbitration
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum[k] = {1'b0, ptr} + (PW+1)'(k);
            cand[k]     = (cand_sum[k] >= (PW+1)'(NUM_REQ))
                        ? cand_sum[k] - (PW+1)'(NUM_REQ)
                        : cand_sum[k];
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (in_enable && !in_reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_any && in_req_valid[cand[k][PW-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = cand[k][PW-1:0];
                end
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (grant_any) begin
            ptr_next = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

    assign out_req_ready = grant;

    // ------------------------------------------------------------------
    // Inverter input drive
    // ------------------------------------------------------------------
`ifdef MASKED_INV_SCHED_IDLE_ZERO_EN
    // Zero shares on idle cycles keep stale operands off the inverter inputs.
    assign idle_a = '0;
`else
    // Holding the last operand means the inverter inputs do not toggle while idle.
    logic [NUM_SHARES-1:0][7:0] last_a;

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            last_a <= '0;
        end else if (grant_any) begin
            last_a <= in_req_data[grant_idx];
        end
    end

    assign idle_a = last_a;
`endif

    always_comb begin
        out_inv_a = idle_a;
        if (in_reset) begin
            out_inv_a = '0;
        end else if (grant_any) begin
            out_inv_a = in_req_data[grant_idx];
        end
    end

    // ------------------------------------------------------------------
    // Valid/ID tracking pipeline, lock-step with the inverter
    // ------------------------------------------------------------------
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_valid[i] <= 1'b0;
                stage_id[i]    <= '0;
            end
        end else begin
            stage_valid[0] <= grant_any;
            stage_id[0]    <= grant;
            for (int i = 1; i < LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_id[i]    <= stage_id[i-1];
            end
        end
    end

    always_comb begin
        out_busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            out_busy = out_busy | stage_valid[i];
        end
    end

    assign out_resp_valid = stage_valid[LATENCY-1] ? stage_id[LATENCY-1] : '0;
    assign out_resp_data  = in_inv_b;

    // ------------------------------------------------------------------
    // Saturating issue counter
    // ------------------------------------------------------------------
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            out_issue_count <= '0;
        end else if (grant_any && (out_issue_count != 16'hFFFF)) begin
            out_issue_count <= out_issue_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_masked_inv_scheduler.sv
module tb_masked_inv_scheduler;

    localparam int NS  = 2;
    localparam int NR  = 4;
    localparam int LAT = 4;

    logic                    clk = 1'b0;
    logic                    in_reset;
    logic                    in_enable;
    logic [NR-1:0]           req_valid;
    logic [NR-1:0][NS-1:0][7:0] req_data;
    logic [NR-1:0]           req_ready;
    logic [NS-1:0][7:0]      inv_a;
    logic [NS-1:0][7:0]      inv_b;
    logic [NR-1:0]           resp_valid;
    logic [NS-1:0][7:0]      resp_data;
    logic                    busy;
    logic [15:0]             issue_count;

    always #5 clk = ~clk;

    masked_inv_scheduler #(.NUM_SHARES(NS), .NUM_REQ(NR), .LATENCY(LAT)) dut (
        .in_clock        (clk),
        .in_reset        (in_reset),
        .in_enable       (in_enable),
        .in_req_valid    (req_valid),
        .in_req_data     (req_data),
        .out_req_ready   (req_ready),
        .out_inv_a       (inv_a),
        .in_inv_b        (inv_b),
        .out_resp_valid  (resp_valid),
        .out_resp_data   (resp_data),
        .out_busy        (busy),
        .out_issue_count (issue_count)
    );

    // Stand-in inverter: LAT-deep delay with a per-share complement so results
    // are distinguishable from operands.
    logic [NS-1:0][7:0] inv_pipe [LAT];
    always @(posedge clk) begin
        inv_pipe[0] <= inv_a;
        for (int i = 1; i < LAT; i++) inv_pipe[i] <= inv_pipe[i-1];
    end
    assign inv_b = inv_pipe[LAT-1] ^ {NS{8'hFF}};

    typedef struct {
        int          due;
        logic [NR-1:0] id;
        logic [15:0] data;
    } sb_t;

    sb_t         sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          m_ptr    = 0;
    int          m_count  = 0;
    logic [15:0] m_last_a = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check every output against the model,
    // then advance the model to match the upcoming clock edge.
    task automatic step(input logic rst, input logic en, input logic [NR-1:0] v,
                        input logic [NR-1:0][NS-1:0][7:0] d);
        int          g;
        logic [15:0] exp_a;
        logic [NR-1:0] exp_rdy;
        sb_t         e;
        @(negedge clk);
        in_reset  = rst;
        in_enable = en;
        req_valid = v;
        req_data  = d;
        #1;
        check("busy", {31'd0, busy}, {31'd0, (sb_q.size() != 0)});
        check("issue_count", {16'd0, issue_count}, m_count);
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            check("resp_valid", {28'd0, resp_valid}, {28'd0, e.id});
            check("resp_data", {16'd0, resp_data}, {16'd0, e.data});
        end else begin
            check("resp_valid_idle", {28'd0, resp_valid}, 32'd0);
        end

        g = -1;
        if (!rst && en) begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
`ifdef MASKED_INV_SCHED_IDLE_ZERO_EN
        exp_a = 16'h0000;
`else
        exp_a = m_last_a;
`endif
        if (rst) exp_a = 16'h0000;
        else if (g >= 0) exp_a = d[g];
        check("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        check("inv_a", {16'd0, inv_a}, {16'd0, exp_a});

        if (rst) begin
            sb_q.delete();
            m_ptr    = 0;
            m_count  = 0;
            m_last_a = '0;
        end else if (g >= 0) begin
            e.due  = cyc + LAT;
            e.id   = exp_rdy;
            e.data = d[g] ^ 16'hFFFF;
            sb_q.push_back(e);
            m_ptr    = (g + 1) % NR;
            m_last_a = d[g];
            if (m_count < 16'hFFFF) m_count++;
        end
        cyc++;
    endtask

    logic [NR-1:0][NS-1:0][7:0] d;

    task automatic rand_data();
        for (int i = 0; i < NR; i++) d[i] = 16'($urandom);
    endtask

    initial begin
        in_reset  = 1'b1;
        in_enable = 1'b0;
        req_valid = '0;
        req_data  = '0;
        d         = '0;

        // Reset, then idle cycles
        step(1, 0, 4'b0000, d);
        step(1, 1, 4'b1111, d);
        for (int i = 0; i < 3; i++) step(0, 1, 4'b0000, d);

        // Single request from requester 1
        d[1] = {8'h5A, 8'h5A ^ 8'h53};
        step(0, 1, 4'b0010, d);
        for (int i = 0; i < 6; i++) step(0, 1, 4'b0000, d);

        // Round-robin fairness after a fresh reset: all valid for 12 cycles
        step(1, 1, 4'b0000, d);
        for (int i = 0; i < 12; i++) begin
            rand_data();
            step(0, 1, 4'b1111, d);
        end
        for (int i = 0; i < 6; i++) step(0, 1, 4'b0000, d);

        // Pointer wrap and skip: grant 2, then only 3 and 0 valid
        rand_data();
        step(0, 1, 4'b0100, d);
        for (int i = 0; i < 4; i++) begin
            rand_data();
            step(0, 1, 4'b1001, d);
        end
        for (int i = 0; i < 6; i++) step(0, 1, 4'b0000, d);

        // Enable gating with two operations in flight
        for (int i = 0; i < 2; i++) begin
            rand_data();
            step(0, 1, 4'b1111, d);
        end
        for (int i = 0; i < 7; i++) begin
            rand_data();
            step(0, 0, 4'b1111, d);
        end

        // Reset mid-flight: three issues, reset, then nothing may come back
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step(0, 1, 4'b0111, d);
        end
        step(1, 1, 4'b0111, d);
        for (int i = 0; i < 6; i++) step(0, 1, 4'b0000, d);
        rand_data();
        step(0, 1, 4'b1111, d);

        // Random traffic with occasional enable drops
        for (int i = 0; i < 60; i++) begin
            rand_data();
            step(0, ($urandom_range(0, 7) != 0), 4'($urandom), d);
        end
        for (int i = 0; i < 8; i++) step(0, 1, 4'b0000, d);

        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
